// File: rtl/i2c_reg_sequencer_if.sv
// Byte-level I2C master handshake between the register sequencer (master modport)
// and the existing byte engine (slave modport).
interface i2c_reg_sequencer_if;
  logic       isReady;
  logic       start;
  logic       send;
  logic [7:0] datasend;
  logic       sended;
  logic       receive;
  logic [7:0] datareceive;
  logic       received;

  modport master (
    input  isReady, sended, datareceive, received,
    output start, send, datasend, receive
  );

  modport slave (
    output isReady, sended, datareceive, received,
    input  start, send, datasend, receive
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Register-transaction sequencer: one command becomes a START / reg / [RESTART] byte
// sequence on the byte-level master handshake, with internal TX and RX buffers.
module i2c_reg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h77,
  parameter int          MAX_LEN    = 22,
  parameter int          LEN_W      = 8,
  parameter int          START_HOLD = 15,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             tx_we,
  input  logic [LEN_W-1:0] tx_addr,
  input  logic [7:0]       tx_data,
  input  logic [LEN_W-1:0] rx_addr,
  output logic [7:0]       rx_data,
  i2c_reg_sequencer_if.master i2c,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_READY = 3'd1;
  localparam logic [2:0] ST_LOAD       = 3'd2;
  localparam logic [2:0] ST_SEND_WAIT  = 3'd3;
  localparam logic [2:0] ST_RECV_REQ   = 3'd4;
  localparam logic [2:0] ST_RECV_WAIT  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  logic [2:0]        state_r;
  logic              rw_r;
  logic [7:0]        reg_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W:0]    seqIdx_r;
  logic [LEN_W-1:0]  rxIdx_r;
  logic [15:0]       toCnt_r;
  logic [HOLD_W-1:0] holdCnt_r;
  logic              start_r, send_r, receive_r, busy_r, done_r, error_r;
  logic [7:0]        datasend_r;
  logic              sendedPrev_r, receivedPrev_r;
  logic [7:0]        txBuf_r [MAX_LEN];
  logic [7:0]        rxBuf_r [MAX_LEN];

  logic              sendedEvt_s, receivedEvt_s, lenBad_s, isAddr_s, waiting_s, abort_s;
  logic [LEN_W:0]    lastSeq_s, txPos_s;
  logic [7:0]        seqByte_s;

  assign sendedEvt_s   = i2c.sended & ~sendedPrev_r;
  assign receivedEvt_s = i2c.received & ~receivedPrev_r;
  assign lenBad_s      = (cmd_len == {LEN_W{1'b0}}) || (cmd_len > LEN_W'(MAX_LEN));
  // Read: addr(W), reg, addr(R) -> last send index 2; write: addr, reg, len payload bytes.
  assign lastSeq_s     = rw_r ? (LEN_W+1)'(2) : ({1'b0, len_r} + (LEN_W+1)'(1));
  assign txPos_s       = seqIdx_r - (LEN_W+1)'(2);
  assign isAddr_s      = (seqIdx_r == (LEN_W+1)'(0)) || (rw_r && (seqIdx_r == (LEN_W+1)'(2)));
  assign abort_s       = waiting_s && (toCnt_r == TIMEOUT);

  assign cmd_ready    = (state_r == ST_IDLE);
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign i2c.start    = start_r;
  assign i2c.send     = send_r;
  assign i2c.datasend = datasend_r;
  assign i2c.receive  = receive_r;

  // Next byte of the sequence for the current index.
  always_comb begin
    seqByte_s = 8'h00;
    if (seqIdx_r == (LEN_W+1)'(0)) begin
      seqByte_s = {DEV_ADDR, 1'b0};
    end else if (seqIdx_r == (LEN_W+1)'(1)) begin
      seqByte_s = reg_r;
    end else if (rw_r) begin
      seqByte_s = {DEV_ADDR, 1'b1};
    end else begin
      seqByte_s = txBuf_r[txPos_s[IDX_W-1:0]];
    end
  end

  // Which waiting states are stalled this cycle (timeout only counts while stalled).
  always_comb begin
    waiting_s = 1'b0;
    case (state_r)
      ST_WAIT_READY: waiting_s = ~i2c.isReady;
      ST_SEND_WAIT:  waiting_s = ~sendedEvt_s;
      ST_RECV_WAIT:  waiting_s = ~receivedEvt_s;
      default:       waiting_s = 1'b0;
    endcase
  end

  // RX read port, zero outside the buffer.
  always_comb begin
    if (rx_addr < LEN_W'(MAX_LEN)) begin
      rx_data = rxBuf_r[rx_addr[IDX_W-1:0]];
    end else begin
      rx_data = 8'h00;
    end
  end

  // TX buffer fill from the command side, locked while a transaction runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) txBuf_r[i] <= 8'h00;
    end else if (tx_we && !busy_r && (tx_addr < LEN_W'(MAX_LEN))) begin
      txBuf_r[tx_addr[IDX_W-1:0]] <= tx_data;
    end
  end

  // Sequencer FSM, handshake outputs and RX capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      rw_r           <= 1'b0;
      reg_r          <= 8'h00;
      len_r          <= {LEN_W{1'b0}};
      seqIdx_r       <= {(LEN_W+1){1'b0}};
      rxIdx_r        <= {LEN_W{1'b0}};
      toCnt_r        <= 16'h0000;
      holdCnt_r      <= {HOLD_W{1'b0}};
      start_r        <= 1'b0;
      send_r         <= 1'b0;
      receive_r      <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      datasend_r     <= 8'h00;
      sendedPrev_r   <= 1'b0;
      receivedPrev_r <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) rxBuf_r[i] <= 8'h00;
    end else begin
      sendedPrev_r   <= i2c.sended;
      receivedPrev_r <= i2c.received;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      toCnt_r        <= 16'h0000;
      // START/RESTART is held for a fixed number of cycles independent of the ack.
      if (start_r) begin
        if (holdCnt_r == {HOLD_W{1'b0}}) start_r <= 1'b0;
        else holdCnt_r <= holdCnt_r - HOLD_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            rw_r     <= cmd_rw;
            reg_r    <= cmd_reg;
            len_r    <= cmd_len;
            seqIdx_r <= {(LEN_W+1){1'b0}};
            rxIdx_r  <= {LEN_W{1'b0}};
            if (lenBad_s) begin
              error_r <= 1'b1;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_WAIT_READY;
            end
          end
        end
        ST_WAIT_READY: begin
          if (i2c.isReady) state_r <= ST_LOAD;
          else toCnt_r <= toCnt_r + 16'd1;
        end
        ST_LOAD: begin
          datasend_r <= seqByte_s;
          send_r     <= 1'b1;
          start_r    <= isAddr_s;
          holdCnt_r  <= HOLD_W'(START_HOLD - 1);
          state_r    <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          if (sendedEvt_s) begin
            send_r   <= 1'b0;
            seqIdx_r <= seqIdx_r + (LEN_W+1)'(1);
            if (seqIdx_r == lastSeq_s) state_r <= rw_r ? ST_RECV_REQ : ST_DONE;
            else state_r <= ST_LOAD;
          end else begin
            toCnt_r <= toCnt_r + 16'd1;
          end
        end
        ST_RECV_REQ: begin
          receive_r <= 1'b1;
          state_r   <= ST_RECV_WAIT;
        end
        ST_RECV_WAIT: begin
          if (receivedEvt_s) begin
            rxBuf_r[rxIdx_r[IDX_W-1:0]] <= i2c.datareceive;
            rxIdx_r   <= rxIdx_r + LEN_W'(1);
            receive_r <= 1'b0;
            state_r   <= ((rxIdx_r + LEN_W'(1)) == len_r) ? ST_DONE : ST_RECV_REQ;
          end else begin
            toCnt_r <= toCnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          send_r    <= 1'b0;
          receive_r <= 1'b0;
          start_r   <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
      if (abort_s) begin
        error_r   <= 1'b1;
        start_r   <= 1'b0;
        send_r    <= 1'b0;
        receive_r <= 1'b0;
        busy_r    <= 1'b0;
        state_r   <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer: a simple byte-master model acks sends and
// returns read data; a monitor logs bytes, start lengths and pulses.
module tb_i2c_reg_sequencer;

  localparam logic [15:0] TMO = 16'd300;
  localparam int ACK_DLY = 20;
  localparam int RD_DLY  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [7:0] cmd_reg, cmd_len;
  logic       tx_we;
  logic [7:0] tx_addr, tx_data, rx_addr, rx_data;
  logic       busy, done, error;

  i2c_reg_sequencer_if bus ();

  i2c_reg_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .tx_we(tx_we), .tx_addr(tx_addr), .tx_data(tx_data),
    .rx_addr(rx_addr), .rx_data(rx_data),
    .i2c(bus),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int         ackLimit = 1000000;
  int         ackedCnt = 0;
  int         rdIdx = 0;
  logic [7:0] rdData [0:31];

  // monitor state
  logic [7:0] sendLog [$];
  int         startRuns [$];
  int         runLen = 0;
  int         cyc = 0, lastSendCyc = 0, errCyc = 0;
  int         doneCnt = 0, errCnt = 0, recvPulses = 0;
  logic       prevSend = 1'b0, prevRecv = 1'b0;

  int doneBase, errBase, sendBase, runBase, recvBase;
  logic [7:0] expSends [$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-master model: acks each presented byte, answers each receive request.
  initial begin
    bus.sended = 1'b0;
    bus.received = 1'b0;
    bus.datareceive = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.send === 1'b1 && ackedCnt < ackLimit) begin
        repeat (ACK_DLY) @(negedge clk);
        bus.sended = 1'b1;
        @(negedge clk);
        bus.sended = 1'b0;
        ackedCnt++;
      end else if (reset === 1'b1 && bus.receive === 1'b1) begin
        repeat (RD_DLY) @(negedge clk);
        bus.datareceive = rdData[rdIdx];
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        rdIdx++;
      end
    end
  end

  // Monitor: byte log, START run lengths, pulse counters.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prevSend <= bus.send;
    prevRecv <= bus.receive;
    if (bus.send && !prevSend) begin
      sendLog.push_back(bus.datasend);
      lastSendCyc <= cyc;
    end
    if (bus.receive && !prevRecv) recvPulses <= recvPulses + 1;
    if (done) doneCnt <= doneCnt + 1;
    if (error) begin
      errCnt <= errCnt + 1;
      errCyc <= cyc;
    end
    if (bus.start) runLen <= runLen + 1;
    else if (runLen != 0) begin
      startRuns.push_back(runLen);
      runLen <= 0;
    end
  end

  task automatic snap();
    doneBase = doneCnt;
    errBase  = errCnt;
    sendBase = sendLog.size();
    runBase  = startRuns.size();
    recvBase = recvPulses;
  endtask

  task automatic issueCmd(input logic rw, input logic [7:0] rg, input logic [7:0] len);
    snap();
    @(negedge clk);
    checkEq("cmd_ready_before", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_reg = rg; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitEnd();
    int n = 0;
    while (doneCnt == doneBase && errCnt == errBase && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkEq("end_within_budget", n < 3000, 1'b1);
    @(negedge clk);
  endtask

  task automatic txWrite(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tx_we = 1'b1; tx_addr = a; tx_data = d;
    @(negedge clk);
    tx_we = 1'b0;
  endtask

  task automatic checkSends();
    checkEq("send_count", sendLog.size() - sendBase, expSends.size());
    for (int i = 0; i < expSends.size(); i++) begin
      if (sendBase + i < sendLog.size()) checkEq($sformatf("send_byte%0d", i), sendLog[sendBase + i], expSends[i]);
      else checkEq($sformatf("send_byte%0d_missing", i), 8'hXX, expSends[i]);
    end
  endtask

  task automatic readRx(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rx_addr = a;
    #1;
    checkEq(tag, rx_data, exp);
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_reg = 8'h00; cmd_len = 8'h00;
    tx_we = 1'b0; tx_addr = 8'h00; tx_data = 8'h00; rx_addr = 8'h00;
    bus.isReady = 1'b1;
    for (int i = 0; i < 32; i++) rdData[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkEq("rst_busy", busy, 1'b0);
    checkEq("rst_send", bus.send, 1'b0);
    checkEq("rst_start", bus.start, 1'b0);
    checkEq("rst_datasend", bus.datasend, 8'h00);
    checkEq("rst_cmd_ready", cmd_ready, 1'b1);
    readRx(8'd0, 8'h00, "rst_rx0");
    reset = 1'b1;

    // Read ID
    rdIdx = 0; rdData[0] = 8'h55;
    issueCmd(1'b1, 8'hD0, 8'd1);
    waitEnd();
    expSends = '{8'hEE, 8'hD0, 8'hEF};
    checkSends();
    checkEq("id_start_runs", startRuns.size() - runBase, 2);
    if (startRuns.size() - runBase == 2) begin
      checkEq("id_start_len0", startRuns[runBase], 15);
      checkEq("id_start_len1", startRuns[runBase + 1], 15);
    end
    readRx(8'd0, 8'h55, "id_rx0");
    checkEq("id_done", doneCnt - doneBase, 1);
    checkEq("id_err", errCnt - errBase, 0);
    checkEq("id_recv_pulses", recvPulses - recvBase, 1);
    checkEq("id_busy_after", busy, 1'b0);

    // Calibration burst
    rdIdx = 0;
    for (int i = 0; i < 22; i++) rdData[i] = 8'(i);
    issueCmd(1'b1, 8'hAA, 8'd22);
    waitEnd();
    for (int i = 0; i < 22; i++) readRx(8'(i), 8'(i), $sformatf("burst_rx%0d", i));
    readRx(8'd22, 8'h00, "burst_rx_oob");
    checkEq("burst_recv_pulses", recvPulses - recvBase, 22);
    checkEq("burst_done", doneCnt - doneBase, 1);

    // Single-byte write
    txWrite(8'd0, 8'h2E);
    issueCmd(1'b0, 8'hF4, 8'd1);
    waitEnd();
    expSends = '{8'hEE, 8'hF4, 8'h2E};
    checkSends();
    checkEq("wr_recv_pulses", recvPulses - recvBase, 0);
    checkEq("wr_done", doneCnt - doneBase, 1);
    checkEq("wr_start_runs", startRuns.size() - runBase, 1);

    // Three-byte write; a TX write while busy must be dropped
    txWrite(8'd0, 8'h11); txWrite(8'd1, 8'h22); txWrite(8'd2, 8'h33);
    issueCmd(1'b0, 8'h10, 8'd3);
    repeat (5) @(negedge clk);
    checkEq("wr3_busy", busy, 1'b1);
    txWrite(8'd0, 8'h99);
    waitEnd();
    expSends = '{8'hEE, 8'h10, 8'h11, 8'h22, 8'h33};
    checkSends();
    issueCmd(1'b0, 8'h20, 8'd1);
    waitEnd();
    expSends = '{8'hEE, 8'h20, 8'h11};
    checkSends();

    // Timeout: only the address byte is acked
    ackedCnt = 0; ackLimit = 1;
    issueCmd(1'b0, 8'hF4, 8'd1);
    waitEnd();
    checkEq("tmo_err", errCnt - errBase, 1);
    checkEq("tmo_done", doneCnt - doneBase, 0);
    checkEq("tmo_delay_window", (errCyc - lastSendCyc >= int'(TMO)) && (errCyc - lastSendCyc <= int'(TMO) + 2), 1'b1);
    checkEq("tmo_send", bus.send, 1'b0);
    checkEq("tmo_cmd_ready", cmd_ready, 1'b1);
    checkEq("tmo_busy", busy, 1'b0);
    ackLimit = 1000000;

    // Bad lengths with the master never ready
    bus.isReady = 1'b0;
    issueCmd(1'b0, 8'hF4, 8'd0);
    waitEnd();
    checkEq("len0_err", errCnt - errBase, 1);
    checkEq("len0_sends", sendLog.size() - sendBase, 0);
    checkEq("len0_cmd_ready", cmd_ready, 1'b1);
    issueCmd(1'b1, 8'hF4, 8'd23);
    waitEnd();
    checkEq("len23_err", errCnt - errBase, 1);
    checkEq("len23_sends", sendLog.size() - sendBase, 0);
    checkEq("len23_busy", busy, 1'b0);
    bus.isReady = 1'b1;

    // Reset in the middle of a 6-byte read
    rdIdx = 0;
    for (int i = 0; i < 6; i++) rdData[i] = 8'(8'hC1 + i);
    issueCmd(1'b1, 8'h40, 8'd6);
    begin
      int n = 0;
      while (rdIdx < 3 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      checkEq("mid_reached_3", n < 3000, 1'b1);
    end
    reset = 1'b0;
    #1;
    checkEq("mid_send", bus.send, 1'b0);
    checkEq("mid_receive", bus.receive, 1'b0);
    checkEq("mid_start", bus.start, 1'b0);
    checkEq("mid_busy", busy, 1'b0);
    checkEq("mid_datasend", bus.datasend, 8'h00);
    for (int i = 0; i < 3; i++) readRx(8'(i), 8'h00, $sformatf("mid_rx%0d", i));
    repeat (5) @(negedge clk);
    checkEq("mid_no_done", doneCnt - doneBase, 0);
    checkEq("mid_no_err", errCnt - errBase, 0);
    reset = 1'b1;
    rdIdx = 0; rdData[0] = 8'hA1; rdData[1] = 8'hA2;
    issueCmd(1'b1, 8'h41, 8'd2);
    waitEnd();
    checkEq("post_done", doneCnt - doneBase, 1);
    readRx(8'd0, 8'hA1, "post_rx0");
    readRx(8'd1, 8'hA2, "post_rx1");
    readRx(8'd2, 8'h00, "post_rx2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
